// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the fetch-side PC sequencer and its return stack:
// default PC width and reset address, the ControlUnit Jump encodings and the
// halt opcode.
// Optional feature macro used by the sequencer: RAS_ERROR_HALT_EN.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP  = 6'b101101;

  // Jump field as produced by ControlUnit; 2'b11 is unused and behaves as none.
  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JS   = 2'b10,
    JMP_RSVD = 2'b11
  } jump_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the ControlUnit-facing control inputs and the fetch/status outputs
// of the PC sequencer.
//   master : drives stall, Jump, link, Branch, br_taken, imm16, target26, halt;
//            observes pc, pc_plus4, ras_top, halted, ras_ovf, ras_unf
//   slave  : the sequencer side (directions reversed)
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int PC_W = 32
);

  logic            stall;
  logic [1:0]      Jump;
  logic            link;
  logic            Branch;
  logic            br_taken;
  logic [15:0]     imm16;
  logic [25:0]     target26;
  logic            halt;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] ras_top;
  logic            halted;
  logic            ras_ovf;
  logic            ras_unf;

  modport master (
    output stall, Jump, link, Branch, br_taken, imm16, target26, halt,
    input  pc, pc_plus4, ras_top, halted, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, Jump, link, Branch, br_taken, imm16, target26, halt,
    output pc, pc_plus4, ras_top, halted, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// Hardware return-address stack: circular buffer of DEPTH entries with a write
// pointer and a saturating occupancy count. A push on a full stack overwrites
// the oldest entry; a pop on an empty stack changes nothing but the
// underflow flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, pop       one-cycle requests (never both at once)
//   push_data       value written on push
//   top             entry[ptr-1] when not empty, else 0
//   empty, full     occupancy status
//   ovf, unf        sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module return_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count;

  // The write pointer always points at the next free slot, so the most
  // recent entry lives one below it (wrapping naturally in PTR_W bits).
  assign top_idx = ptr - 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign top     = empty ? '0 : mem[top_idx];

  // Push/pop bookkeeping. When full, a push still writes and advances the
  // pointer so the oldest entry is replaced, but the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch-side program counter stage. Holds the PC, resolves the next PC from
// ControlUnit's Jump/Branch/halt outputs, owns the return-address stack used
// by JAL (push) and JS (pop) and latches halt until reset.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          pc_sequencer_if.slave: control inputs in, pc/pc_plus4/
//                ras_top/halted/ras_ovf/ras_unf out
// Optional feature: define RAS_ERROR_HALT_EN to make any stack overflow or
// underflow also halt the core, holding pc at the offending instruction.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W      = mips_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter int              RAS_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  import mips_pkg::*;

`ifdef RAS_ERROR_HALT_EN
  localparam bit HALT_ON_RAS_FAULT = 1'b1;
`else
  localparam bit HALT_ON_RAS_FAULT = 1'b0;
`endif

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] ras_top;
  logic            halted_q;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;
  logic            ras_unf;
  logic            active;
  logic            push;
  logic            pop;
  logic            ras_fault;
  jump_t           jump_op;

  assign jump_op    = jump_t'(bus.Jump);
  assign pc_plus4   = pc_q + PC_W'(4);
  assign br_offset  = {{(PC_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jmp_target = {pc_plus4[PC_W-1:28], bus.target26, 2'b00};

  // Stack operations only happen on a cycle that actually advances the PC;
  // halt (pending or latched) and stall both suppress them.
  assign active    = !halted_q && !bus.halt && !bus.stall;
  assign push      = active && (jump_op == JMP_J) && bus.link;
  assign pop       = active && (jump_op == JMP_JS);
  assign ras_fault = (push && ras_full) || (pop && ras_empty);

  return_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  // Next-PC selection in priority order: halt, stall, optional fault halt,
  // then JS / J / branch / sequential. A JS on an empty stack falls through
  // to pc+4. Jump=11 lands in the default arm with no stack effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (halted_q || bus.halt) begin
      halted_q <= 1'b1;
    end else if (bus.stall) begin
      pc_q <= pc_q;
    end else if (HALT_ON_RAS_FAULT && ras_fault) begin
      halted_q <= 1'b1;
    end else begin
      case (jump_op)
        JMP_JS:  pc_q <= ras_empty ? pc_plus4 : ras_top;
        JMP_J:   pc_q <= jmp_target;
        default: begin
          if (bus.Branch && bus.br_taken) begin
            pc_q <= pc_plus4 + br_offset;
          end else begin
            pc_q <= pc_plus4;
          end
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.ras_top  = ras_top;
  assign bus.halted   = halted_q;
  assign bus.ras_ovf  = ras_ovf;
  assign bus.ras_unf  = ras_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer: reset, sequential fetch, branches, JAL/JS,
// stack overflow/underflow, Jump=11, halt and stall. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// Honours RAS_ERROR_HALT_EN for the overflow/underflow section.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] expPc;
  logic [31:0] links[$];

  pc_sequencer_if #(.PC_W(32)) bus ();

  pc_sequencer #(
    .PC_W      (32),
    .RESET_PC  (32'h0000_0000),
    .RAS_DEPTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every control input at once.
  task automatic applyStimulus(input logic stall, input logic [1:0] jump,
                               input logic link, input logic branch,
                               input logic taken, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic halt);
    bus.stall    = stall;
    bus.Jump     = jump;
    bus.link     = link;
    bus.Branch   = branch;
    bus.br_taken = taken;
    bus.imm16    = imm;
    bus.target26 = tgt;
    bus.halt     = halt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and report a failure with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic h, input logic o,
                            input logic u);
    checkOutput({tag, "_halted"}, {31'b0, bus.halted}, {31'b0, h});
    checkOutput({tag, "_ovf"},    {31'b0, bus.ras_ovf}, {31'b0, o});
    checkOutput({tag, "_unf"},    {31'b0, bus.ras_unf}, {31'b0, u});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #2;
    checkOutput("reset_pc", bus.pc, 32'h0);
    checkOutput("reset_pc_plus4", bus.pc_plus4, 32'h4);
    checkOutput("reset_ras_top", bus.ras_top, 32'h0);
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    // Free-running fetch.
    tick(); checkOutput("seq_4", bus.pc, 32'h4);
    tick(); checkOutput("seq_8", bus.pc, 32'h8);
    tick(); checkOutput("seq_c", bus.pc, 32'hC);

    // Asynchronous reset mid-run takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pc", bus.pc, 32'h0);
    checkFlags("midreset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    repeat (4) tick();
    checkOutput("at_10", bus.pc, 32'h10);

    // Taken branch backwards: 0x14 + (-2 << 2) = 0x0C.
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 16'hFFFE, 26'h0, 1'b0);
    tick(); checkOutput("br_taken", bus.pc, 32'hC);
    idle();
    tick(); checkOutput("back_10", bus.pc, 32'h10);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0, 1'b0);
    tick(); checkOutput("br_not_taken", bus.pc, 32'h14);

    idle();
    repeat (3) tick();
    checkOutput("at_20", bus.pc, 32'h20);
    checkOutput("plus4_24", bus.pc_plus4, 32'h24);

    // JAL then JS round trip.
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 26'h40, 1'b0);
    tick();
    checkOutput("jal_pc", bus.pc, 32'h100);
    checkOutput("jal_top", bus.ras_top, 32'h24);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    tick();
    checkOutput("js_pc", bus.pc, 32'h24);
    checkOutput("js_empty_top", bus.ras_top, 32'h0);

    // Jump=11 acts as no jump: sequential advance, nothing pushed.
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0, 26'h40, 1'b0);
    tick();
    checkOutput("jmp11_pc", bus.pc, 32'h28);
    checkOutput("jmp11_top", bus.ras_top, 32'h0);

    // Eight JALs fill the stack; targets 0x100, 0x200, ... 0x800.
    expPc = 32'h28;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 26'(i * 'h40), 1'b0);
      links.push_back(expPc + 32'h4);
      expPc = 32'(i * 'h100);
      tick();
      checkOutput("fill_pc", bus.pc, expPc);
      checkOutput("fill_top", bus.ras_top, links[$]);
    end
    checkOutput("full_no_ovf", {31'b0, bus.ras_ovf}, 32'h0);

    // Ninth JAL at 0x800 overflows.
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 26'h240, 1'b0);
    tick();
`ifdef RAS_ERROR_HALT_EN
    checkOutput("ovf_halt_pc", bus.pc, 32'h800);
    checkFlags("ovf_halt", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    idle();
    repeat (32) tick();
    checkOutput("at_80", bus.pc, 32'h80);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    tick();
    checkOutput("unf_halt_pc", bus.pc, 32'h80);
    checkFlags("unf_halt", 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("unf_halt_hold", bus.pc, 32'h80);
`else
    links.push_back(32'h804);
    checkOutput("ovf_pc", bus.pc, 32'h900);
    checkFlags("ovf", 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_top", bus.ras_top, 32'h804);

    // Eight JS return the last eight links, newest first.
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      expPc = links.pop_back();
      tick();
      checkOutput("lifo_pc", bus.pc, expPc);
    end
    checkOutput("drained_top", bus.ras_top, 32'h0);
    checkOutput("drained_no_unf", {31'b0, bus.ras_unf}, 32'h0);

    // Ninth JS underflows and just advances.
    tick();
    checkOutput("unf_pc", bus.pc, 32'h108);
    checkFlags("unf", 1'b0, 1'b1, 1'b1);
`endif

    // Reset clears every sticky flag.
    rst_n = 1'b0;
    #1;
    checkFlags("reset2", 1'b0, 1'b0, 1'b0);
    checkOutput("reset2_pc", bus.pc, 32'h0);
    rst_n = 1'b1;

    // Push one link, arrive at 0x40, then halt together with a JAL.
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 26'h10, 1'b0);
    tick();
    checkOutput("pre_halt_pc", bus.pc, 32'h40);
    checkOutput("pre_halt_top", bus.ras_top, 32'h4);
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0, 26'h50, 1'b1);
    tick();
    checkOutput("halt_pc", bus.pc, 32'h40);
    checkOutput("halt_top", bus.ras_top, 32'h4);
    checkOutput("halt_flag", {31'b0, bus.halted}, 32'h1);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    repeat (3) tick();
    checkOutput("halted_hold_pc", bus.pc, 32'h40);
    checkOutput("halted_hold_top", bus.ras_top, 32'h4);
    checkOutput("halted_sticky", {31'b0, bus.halted}, 32'h1);

    rst_n = 1'b0;
    #1;
    checkOutput("reset3_halted", {31'b0, bus.halted}, 32'h0);
    rst_n = 1'b1;
    idle();

    // Stall freezes a pending taken branch for one cycle.
    tick();
    checkOutput("stall_pre", bus.pc, 32'h4);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0, 1'b0);
    tick();
    checkOutput("stall_hold", bus.pc, 32'h4);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0, 1'b0);
    tick();
    checkOutput("stall_release_br", bus.pc, 32'h48);
    idle();
    tick();
    checkOutput("after_stall_seq", bus.pc, 32'h4C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side program-counter stage that sits directly upstream of ControlUnit.
- Holds the PC, drives the instruction-memory address, and resolves the next PC from ControlUnit's Jump, Branch and halt outputs.
- Owns the hardware return-address stack used by JAL (push) and JS (pop).
- Latches halt so the core stops fetching until reset.

Parameters:
- PC_W, 32, width of PC and all addresses (byte address, word aligned).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 8, return-stack entries (power of two, at least 2).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hold PC and stack this cycle.
- Jump  in  2  from ControlUnit: 01 = J/JAL, 10 = JS (pop), 00 = none.
- link  in  1  MemtoReg[1] & ~Jump[1]; qualifies a 01 jump as JAL (push).
- Branch  in  1  from ControlUnit.
- br_taken  in  1  ALU compare result for the current branch.
- imm16  in  16  branch offset in words.
- target26  in  26  jump target field.
- halt  in  1  from ControlUnit.
- pc  out  PC_W  current fetch address.
- pc_plus4  out  PC_W  pc+4; JAL link value written to R31.
- ras_top  out  PC_W  top-of-stack value; JS write-back data.
- halted  out  1  sticky halt status.
- ras_ovf  out  1  sticky overflow flag.
- ras_unf  out  1  sticky underflow flag.

Behaviour:
- Reset (Reset=0, asynchronous) sets:
  - pc = RESET_PC
  - halted = 0, ras_ovf = 0, ras_unf = 0
  - stack count = 0, stack pointer = 0, ras_top = 0
- pc_plus4 is combinational: pc + 4, modulo 2^PC_W.
- Next-PC selection each rising edge, in priority order:
  1. halted=1 or halt=1: pc holds; halted <- 1. The instruction carrying halt does not advance the PC.
  2. stall=1: pc, stack and flags all hold.
  3. Jump=10 (JS): pc <- stack top; pop (count-1).
  4. Jump=01: pc <- {pc_plus4[PC_W-1:28], target26, 2'b00}. If link=1, also push pc_plus4.
  5. Jump=11: treated as 00.
  6. Branch=1 and br_taken=1: pc <- pc_plus4 + (sext(imm16) << 2), wrapping modulo 2^PC_W.
  7. Otherwise: pc <- pc_plus4.
- Latency: the next PC is visible on pc one cycle after the control inputs are sampled. There is no delay slot.
- Stack: circular buffer of RAS_DEPTH entries with a write pointer and a saturating count 0..RAS_DEPTH.
  - ras_top = entry[ptr-1] when count>0, else 0. It is combinational from registered state.
- Push when count = RAS_DEPTH: the oldest entry is overwritten, count stays RAS_DEPTH, ras_ovf <- 1.
- Pop when count = 0:
  - pc <- pc_plus4 (treated as no-op), ras_unf <- 1, pointer unchanged.
- halt asserted together with Jump or Branch in the same cycle: halt wins; no push or pop.
- ras_ovf, ras_unf and halted clear only on reset.
- Reset asserted mid-operation: all state is lost immediately. Deassertion is synchronised externally. The first fetch after deassertion is from RESET_PC.

Optional Feature:
- Macro: RAS_ERROR_HALT_EN.
- Defined: a stack overflow or underflow event also sets halted in the same edge. pc holds at the offending instruction's address, not the jump target.
- Undefined: overflow wraps and underflow is a no-op, as described above; halted is unaffected.

Decomposition:
- Shared package mips_pkg holds:
  - Jump encodings JMP_NONE/JMP_J/JMP_JS
  - RESET_PC default
  - halt opcode 6'b101101
  - PC_W
- One sub-module: return_stack. It contains the circular buffer, pointer, count, push/pop/ovf/unf logic and ras_top.
- pc_sequencer owns next-PC muxing and halt.

Test Plan:
- Reset then 3 free-running cycles -> pc = 0, 4, 8, 12; after asserting Reset=0 mid-run -> pc = 0 at once, flags = 0.
- At pc=0x10, Branch=1, br_taken=1, imm16=0xFFFE -> next pc = 0x0C; same with br_taken=0 -> 0x14.
- At pc=0x0000_0020, JAL with target26=0x40 -> pc = 0x100 and ras_top = 0x24; then JS -> pc = 0x24, count = 0.
- Nine JALs with RAS_DEPTH=8 -> ras_ovf = 1; eight JS return the last 8 link addresses in LIFO order; a ninth JS -> ras_unf = 1 and pc advances by 4.
- halt=1 at pc=0x40 together with Jump=01 -> pc stays 0x40 forever, halted = 1, stack unchanged; stall=1 with a branch -> pc holds one cycle.
- With RAS_ERROR_HALT_EN, JS on an empty stack at pc=0x80 -> halted = 1, pc holds 0x80.
